uart_rx_frame: RTL

- 8N1 UART receiver for the UARTCom serial link. Pairs with the team's transmit path.
- Contains its own bit-period counter and samples each bit at mid-bit.
- Reassembles one byte per frame and presents it with a single-cycle valid strobe to the downstream display/command logic.
- Detects false starts (glitches) and framing errors.

---
 rtl/uart_rx_frame.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined): mid-bit sampling, one byte per frame.
// Latency: valid pulses 1 clk after the stop-bit sample, ~9.5 bit periods + 3 clk after the start edge.
// Backpressure: none; data/valid/frame_err are single-cycle strobes that the consumer must take when offered.
module uart_rx_frame #(
    parameter int BIT_CNT  = 10416,
    parameter int HALF_CNT = BIT_CNT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // Sample points: the last cycle of the half-bit (start) and of each full bit period.
    localparam logic [17:0] C_BIT_LAST  = 18'(BIT_CNT - 1);
    localparam logic [17:0] C_HALF_LAST = 18'(HALF_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [17:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;

    logic        w_fall;
    logic        w_bit_end;
    logic        w_half_end;
    logic        w_shift_en;
    logic        w_good_nxt;
    logic        w_ferr_nxt;

`ifdef UART_RX_PARITY_EN
    logic        r_par;
    logic        r_parity_err;
    logic        w_par_smp;
    logic        w_perr_nxt;
`endif

    // Bring rx into the clk domain and remember the previous synchronized value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // A start is only a true 1->0 transition, so a line held low never re-triggers.
    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_bit_end  = (r_cnt == C_BIT_LAST);
    assign w_half_end = (r_cnt == C_HALF_LAST);

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the sample/strobe decisions taken at each sample point.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_good_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_smp   = 1'b0;
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Line back high at mid start bit means it was a glitch.
                if (w_half_end) begin
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving mid stop bit leaves half a bit to catch the next start edge.
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    if (!r_rx_s) begin
                        w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{r_shift, r_par}) begin
                        w_perr_nxt = 1'b1;
`endif
                    end else begin
                        w_good_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit-period counter: restarts on every state change and after each data bit, idles at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state || r_state == S_IDLE || w_shift_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 18'd1;
        end
    end

    // Assemble data bits LSB first; the index restarts whenever a new frame leaves START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else if (r_state == S_START) begin
            r_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_shift[r_idx] <= r_rx_s;
            if (r_idx != 3'd7) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the parity bit and register the parity error strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_smp) begin
                r_par <= r_rx_s;
            end
            r_parity_err <= w_perr_nxt;
        end
    end

    assign parity_err = r_parity_err;
`endif

    // Registered result strobes; data only moves on a fully good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_good_nxt;
            r_frame_err <= w_ferr_nxt;
            if (w_good_nxt) begin
                r_data <= r_shift;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule
